// File: rtl/transform_pair.sv
// Radix-2 DIF stage feeder: buffers the first half of each frame, pairs sample k with k+LENGTH/2 and attaches W^k.
// Optional frame-marker support (s_last, m_last, frame_err) is enabled by defining TRANSFORM_PAIR_LAST_EN.
module transform_pair #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [2*WIDTH-1:0]           s_data,
`ifdef TRANSFORM_PAIR_LAST_EN
    input  logic                         s_last,
    output logic                         m_last,
    output logic                         frame_err,
`endif
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [2:0][2*WIDTH-1:0]      m_data
);

    localparam int HALF = LENGTH / 2;
    localparam int IW   = $clog2(LENGTH);
    localparam int KW   = IW - 1;

    typedef logic [2*WIDTH-1:0] sample_t;

    logic [IW-1:0] idx;
    logic [KW-1:0] k;
    sample_t       sample_buf [HALF];
    sample_t       tw         [HALF];
    logic          fill;
    logic          idx_last;
    logic          accept;
    logic          pair_accept;
    logic          resync;

    // Twiddle W^k = cos - j*sin, rounded half away from zero and saturated to the Q1 range.
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = 2.0 ** (WIDTH - 1);
    localparam real MAX_V = SCALE - 1.0;

    for (genvar g = 0; g < HALF; g++) begin : g_tw
        localparam real RE   = $cos(2.0 * PI * g / LENGTH) * SCALE;
        localparam real IM   = -$sin(2.0 * PI * g / LENGTH) * SCALE;
        localparam real RE_R = (RE >= 0.0) ? $floor(RE + 0.5) : -$floor(0.5 - RE);
        localparam real IM_R = (IM >= 0.0) ? $floor(IM + 0.5) : -$floor(0.5 - IM);
        localparam real RE_S = (RE_R > MAX_V) ? MAX_V : RE_R;
        localparam real IM_S = (IM_R > MAX_V) ? MAX_V : ((IM_R < -SCALE) ? -SCALE : IM_R);
        localparam int  RE_I = $rtoi(RE_S);
        localparam int  IM_I = $rtoi(IM_S);
        assign tw[g] = {WIDTH'(IM_I), WIDTH'(RE_I)};
    end

    assign fill        = !idx[IW-1];
    assign k           = idx[KW-1:0];
    assign idx_last    = (idx == IW'(LENGTH - 1));
    assign s_ready     = fill || !m_valid || m_ready;
    assign accept      = s_valid && s_ready;
    assign pair_accept = accept && !fill;

`ifdef TRANSFORM_PAIR_LAST_EN
    assign resync = accept && s_last && !idx_last;
`else
    assign resync = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (accept) begin
                idx <= (idx_last || resync) ? '0 : idx + 1'b1;
            end
            // A new pair overwrites the output even while a drain happens in the same cycle.
            if (pair_accept) begin
                m_data  <= {tw[k], s_data, sample_buf[k]};
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // NOTE: the sample buffer has no reset; its contents are always written before being read.
    always_ff @(posedge clk) begin
        if (accept && fill) begin
            sample_buf[k] <= s_data;
        end
    end

`ifdef TRANSFORM_PAIR_LAST_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_last    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (pair_accept) begin
                m_last <= (k == KW'(HALF - 1));
            end
            if (resync) begin
                frame_err <= 1'b1;
            end
        end
    end
`endif

    idx_range : assert property (@(posedge clk) disable iff (!reset_n)
        {1'b0, idx} < (IW + 1)'(LENGTH));

    hold_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (m_valid && !m_ready) |=> $stable(m_data));

endmodule

// File: tb/tb_transform_pair.sv
// Directed and random stimulus for transform_pair (LENGTH=8) with a scoreboard queue of expected output triples.
module tb_transform_pair;

    localparam int WIDTH  = 16;
    localparam int LENGTH = 8;
    localparam int HALF   = LENGTH / 2;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [31:0]      s_data  = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [2:0][31:0] m_data;
`ifdef TRANSFORM_PAIR_LAST_EN
    logic             s_last  = 1'b0;
    logic             m_last;
    logic             frame_err;
    logic             exp_err = 1'b0;
`endif

    int          checks    = 0;
    int          errors    = 0;
    int          midx      = 0;
    int          stall_cnt = 0;
    bit          rand_mode = 1'b0;
    logic        prev_hold = 1'b0;
    logic [95:0] prev_data = '0;
    logic [31:0] mbuf   [HALF];
    logic [31:0] tw_exp [HALF] = '{32'h00007FFF, 32'hA57E5A82, 32'h80000000, 32'hA57EA57E};
    logic [96:0] q [$];

    transform_pair #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef TRANSFORM_PAIR_LAST_EN
        .s_last    (s_last),
        .m_last    (m_last),
        .frame_err (frame_err),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [96:0] observed, input logic [96:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, update the model for the coming rising edge.
    task automatic step(input logic v, input logic [31:0] d, output logic acc);
        logic        mr;
        logic        hold;
        logic [96:0] e;
        int          old_idx;
        if (stall_cnt > 0) begin
            mr = 1'b0;
            stall_cnt--;
        end else if (rand_mode) begin
            mr = 1'($urandom_range(0, 1));
        end else begin
            mr = 1'b1;
        end
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        #1;
        if (prev_hold) check("hold_stable", m_data, prev_data);
        check("m_valid", m_valid, q.size() != 0);
        check("s_ready", s_ready, (midx < HALF) || (q.size() == 0) || mr);
`ifdef TRANSFORM_PAIR_LAST_EN
        check("frame_err", frame_err, exp_err);
`endif
        hold = (q.size() != 0) && !mr;
        if (q.size() != 0 && mr) begin
            e = q.pop_front();
            check("beat_data", m_data, e[95:0]);
`ifdef TRANSFORM_PAIR_LAST_EN
            check("m_last", m_last, e[96]);
`endif
        end
        prev_hold = hold;
        prev_data = m_data;
        acc = v && s_ready;
        if (acc) begin
            old_idx = midx;
            if (midx < HALF) mbuf[midx] = d;
            else q.push_back({midx == LENGTH - 1, tw_exp[midx - HALF], d, mbuf[midx - HALF]});
            midx = (midx + 1) % LENGTH;
`ifdef TRANSFORM_PAIR_LAST_EN
            if (s_last && old_idx != LENGTH - 1) begin
                midx    = 0;
                exp_err = 1'b1;
            end
`endif
        end
    endtask

    task automatic send(input logic [31:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        if (rand_mode) begin
            while ($urandom_range(0, 1) == 1 && n < 4) begin
                step(1'b0, $urandom, acc);
                n++;
            end
        end
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            step(1'b1, d, acc);
            n++;
        end
        if (!acc) check("send_timeout", acc, 1'b1);
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, acc);
        check("drain_empty", q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        s_valid = 1'b0;
        m_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 96'h0);
        check("rst_s_ready", s_ready, 1'b1);
        q.delete();
        midx      = 0;
        prev_hold = 1'b0;
`ifdef TRANSFORM_PAIR_LAST_EN
        exp_err = 1'b0;
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_m_last", m_last, 1'b0);
`endif
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // Power-on reset.
        pulse_reset();

        // Basic frame, m_ready always high.
        for (int i = 1; i <= 8; i++) send(32'(i));
        drain(3);

        // Output stall for 5 cycles right after the first beat appears.
        for (int i = 1; i <= 5; i++) send(32'(i));
        stall_cnt = 5;
        for (int i = 6; i <= 8; i++) send(32'(i));
        drain(3);

        // Back-to-back frames with the last beat of frame 1 stalled over the boundary.
        for (int i = 1; i <= 8; i++) send(32'(i));
        stall_cnt = 6;
        for (int i = 9; i <= 16; i++) send(32'(i));
        drain(3);

        // Asynchronous reset mid-frame, then a clean frame.
        for (int i = 1; i <= 6; i++) send(32'(i));
        pulse_reset();
        for (int i = 1; i <= 8; i++) send(32'(i + 100));
        drain(3);

        // Random valid/ready over 100 frames.
        rand_mode = 1'b1;
        for (int i = 0; i < 100 * LENGTH; i++) send($urandom);
        rand_mode = 1'b0;
        drain(3);

`ifdef TRANSFORM_PAIR_LAST_EN
        // Early s_last on sample 6 forces a resync.
        for (int i = 1; i <= 5; i++) send(32'(i));
        s_last = 1'b1;
        send(32'd6);
        s_last = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'(i + 200));
        drain(3);
        check("frame_err_sticky", frame_err, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
